// File: rtl/sensor_stim_tx_pkg.sv
// Shared types and helpers for the sensor stimulus transmitter.
// Holds the FSM encoding, result codes and the zone one-hot helpers.
package sensor_stim_tx_pkg;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_DRIVE    = 2'd1,
      ST_WAIT_ACK = 2'd2,
      ST_GAP      = 2'd3
   } state_e;

   localparam logic [1:0] FC_PASS   = 2'd0;
   localparam logic [1:0] FC_NORESP = 2'd1;
   localparam logic [1:0] FC_WRONG  = 2'd2;
   localparam logic [1:0] FC_SPUR   = 2'd3;

   // Zone 0 is the quiet test and drives no sensor.
   function automatic logic [2:0] zone_onehot(input logic [1:0] zone);
      logic [2:0] oh;
      oh = 3'b000;
      case (zone)
         2'd1:    oh = 3'b001;
         2'd2:    oh = 3'b010;
         2'd3:    oh = 3'b100;
         default: oh = 3'b000;
      endcase
      return oh;
   endfunction

   function automatic logic is_onehot(input logic [2:0] v);
      return (v == 3'b001) || (v == 3'b010) || (v == 3'b100);
   endfunction

endpackage

// File: rtl/sensor_stim_tx.sv
// Zone self-test transmitter: drives a one-hot sensor pattern for a programmed
// hold time, then grades the first buzzer response seen against the zone.
module sensor_stim_tx
   import sensor_stim_tx_pkg::*;
#(
   parameter int HOLD_W     = 5,
   parameter int TIMEOUT    = 40,
   parameter int GAP_CYCLES = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ena,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [1:0]        req_zone,
   input  logic [HOLD_W-1:0] req_hold,
   output logic [2:0]        sensor_out,
   input  logic [2:0]        buzz_in,
   output logic              done,
   output logic              pass,
   output logic [1:0]        fail_code,
   output logic              busy,
   output state_e            state_dbg
);

   localparam int CNT_MAX = (TIMEOUT > GAP_CYCLES) ? TIMEOUT : GAP_CYCLES;
   localparam int CW      = $clog2(CNT_MAX + 1);
   localparam logic [CW-1:0]     TO_LAST  = CW'(TIMEOUT - 1);
   localparam logic [CW-1:0]     GAP_LAST = CW'(GAP_CYCLES - 1);
   localparam logic [CW-1:0]     CNT_ONE  = CW'(1);
   localparam logic [HOLD_W-1:0] HOLD_ONE = HOLD_W'(1);

   state_e            state;
   logic [1:0]        zone_r;
   logic [HOLD_W-1:0] hold_cnt;
   logic [CW-1:0]     to_cnt;
   logic [CW-1:0]     gap_cnt;
   logic [2:0]        obs;
   logic [1:0]        res_code;

   // Handshake: a request is taken on any enabled edge where req_valid and
   // req_ready are both high; req_ready is high only in IDLE, nothing queues.
   assign req_ready = (state == ST_IDLE);
   assign busy      = (state != ST_IDLE);
   assign state_dbg = state;

   // Grade only used on WAIT_ACK exit, where obs == 0 means a timeout.
   always_comb begin
      res_code = FC_PASS;
      if (obs != 3'b000) begin
         if (!is_onehot(obs) || (zone_r == 2'd0)) begin
            res_code = FC_SPUR;
         end else if (obs != zone_onehot(zone_r)) begin
            res_code = FC_WRONG;
         end
      end else if (zone_r != 2'd0) begin
         res_code = FC_NORESP;
      end
   end

   always_ff @(posedge clk) begin
      if (ena) begin
         if (!rst_n) begin
            state      <= ST_IDLE;
            sensor_out <= 3'b000;
            done       <= 1'b0;
            pass       <= 1'b0;
            fail_code  <= FC_PASS;
            zone_r     <= 2'd0;
            hold_cnt   <= '0;
            to_cnt     <= '0;
            gap_cnt    <= '0;
            obs        <= 3'b000;
         end else begin
            done <= 1'b0;
            // buzz_in is sampled raw; only the first nonzero value counts.
            if (((state == ST_DRIVE) || (state == ST_WAIT_ACK)) &&
                (obs == 3'b000) && (buzz_in != 3'b000)) begin
               obs <= buzz_in;
            end
            case (state)
               ST_IDLE: begin
                  if (req_valid) begin
                     zone_r     <= req_zone;
                     hold_cnt   <= (req_hold == '0) ? HOLD_ONE : req_hold;
                     obs        <= 3'b000;
                     sensor_out <= zone_onehot(req_zone);
                     state      <= ST_DRIVE;
                  end
               end
               ST_DRIVE: begin
                  if (hold_cnt <= HOLD_ONE) begin
                     sensor_out <= 3'b000;
                     to_cnt     <= '0;
                     state      <= ST_WAIT_ACK;
                  end else begin
                     hold_cnt <= hold_cnt - HOLD_ONE;
                  end
               end
               ST_WAIT_ACK: begin
                  if ((obs != 3'b000) || (to_cnt >= TO_LAST)) begin
                     done      <= 1'b1;
                     pass      <= (res_code == FC_PASS);
                     fail_code <= res_code;
                     gap_cnt   <= '0;
                     state     <= ST_GAP;
                  end else begin
                     to_cnt <= to_cnt + CNT_ONE;
                  end
               end
               ST_GAP: begin
                  if (buzz_in != 3'b000) begin
                     gap_cnt <= '0;
                  end else if (gap_cnt >= GAP_LAST) begin
                     state <= ST_IDLE;
                  end else begin
                     gap_cnt <= gap_cnt + CNT_ONE;
                  end
               end
               default: state <= ST_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_sensor_stim_tx.sv
// Bench for sensor_stim_tx: directed test-plan cases plus randomized requests,
// graded against a timeline model kept in enabled-edge indices.
`timescale 1ns/1ps
module tb_sensor_stim_tx;
   import sensor_stim_tx_pkg::*;

   localparam int HOLD_W     = 5;
   localparam int TIMEOUT    = 40;
   localparam int GAP_CYCLES = 8;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              ena = 1'b1;
   logic              req_valid = 1'b0;
   logic [1:0]        req_zone = 2'd0;
   logic [HOLD_W-1:0] req_hold = '0;
   logic [2:0]        buzz_in = 3'b000;
   logic              req_ready;
   logic [2:0]        sensor_out;
   logic              done;
   logic              pass;
   logic [1:0]        fail_code;
   logic              busy;
   state_e            state_dbg;

   int          n_cmp = 0;
   int          n_bad = 0;
   int          ecyc = 0;
   bit          ena_rand = 1'b0;
   logic [34:0] exp_q[$];
   logic        last_pass = 1'b0;
   logic [1:0]  last_code = 2'd0;
   bit          held_chk = 1'b0;
   logic [2:0]  sched [0:255];

   sensor_stim_tx #(.HOLD_W(HOLD_W), .TIMEOUT(TIMEOUT), .GAP_CYCLES(GAP_CYCLES)) dut (
      .clk(clk), .rst_n(rst_n), .ena(ena), .req_valid(req_valid), .req_ready(req_ready),
      .req_zone(req_zone), .req_hold(req_hold), .sensor_out(sensor_out), .buzz_in(buzz_in),
      .done(done), .pass(pass), .fail_code(fail_code), .busy(busy), .state_dbg(state_dbg)
   );

   // Clock, enabled-edge counter, enable generator and watchdog.
   always #5 clk = ~clk;
   always @(posedge clk) if (ena) ecyc <= ecyc + 1;

   initial forever begin
      @(posedge clk);
      #1;
      ena = ena_rand ? ($urandom_range(0, 1) == 1) : 1'b1;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: time limit reached, %0d results still pending", exp_q.size());
      $fatal;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h (enabled edge %0d)", name, act, exp, ecyc);
      end
   endtask

   // Advance to just after the next enabled clock edge.
   task automatic step();
      bit en;
      do begin
         @(posedge clk);
         en = ena;
      end while (!en);
      #2;
   endtask

   // Scoreboard monitor: a done pulse is consumed at an enabled edge.
   always @(negedge clk) begin
      logic [34:0] e;
      if (ena) begin
         if (done) begin
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL unexpected_done: pass=%0b code=%0d at edge %0d with no result pending",
                        pass, fail_code, ecyc);
            end else begin
               e = exp_q.pop_front();
               n_cmp++;
               if ({pass, fail_code, ecyc} !== e) begin
                  n_bad++;
                  $display("FAIL done_result: got pass=%0b code=%0d edge=%0d, expected pass=%0b code=%0d edge=%0d",
                           pass, fail_code, ecyc, e[34], e[33:32], e[31:0]);
               end
               last_pass = e[34];
               last_code = e[33:32];
               held_chk  = 1'b1;
            end
         end else if (held_chk) begin
            check("result_held", {pass, fail_code}, {last_pass, last_code});
         end
      end
   end

   // One request. The pulse value v is on buzz_in for enabled edges s..s+d-1,
   // counted from the accept edge (edge 0).
   task automatic run_txn(input logic [1:0] z, input logic [HOLD_W-1:0] hd, input int s,
                          input int d, input logic [2:0] v, input bit keep_valid);
      int         h;
      int         f;
      int         ex;
      int         j;
      int         rdy;
      bit         ok;
      logic [2:0] obs;
      logic [2:0] zoh;
      logic [1:0] code;
      h   = (hd == '0) ? 1 : int'(hd);
      zoh = (z == 2'd0) ? 3'b000 : (3'b001 << (z - 2'd1));
      foreach (sched[k]) sched[k] = 3'b000;
      for (int k = s; (k < s + d) && (k < 256); k++) if (k >= 1) sched[k] = v;
      // Drive is edges 1..h, listening lasts TIMEOUT edges after that.
      f = 0;
      for (int k = 1; k <= h + TIMEOUT - 1; k++) if ((f == 0) && (sched[k] != 3'b000)) f = k;
      if (f != 0) begin
         obs = sched[f];
         ex  = (f + 1 > h + 1) ? f + 1 : h + 1;
         if (($countones(obs) != 1) || (z == 2'd0)) code = 2'd3;
         else if (obs != zoh) code = 2'd2;
         else code = 2'd0;
      end else begin
         ex   = h + TIMEOUT;
         code = (z == 2'd0) ? 2'd0 : 2'd1;
      end
      // Ready returns after GAP_CYCLES consecutive quiet edges following the result.
      j = ex + 1;
      forever begin
         ok = 1'b1;
         for (int m = 0; m < GAP_CYCLES; m++) if (sched[j + m] != 3'b000) ok = 1'b0;
         if (ok) break;
         j++;
      end
      rdy = j + GAP_CYCLES;

      check("ready_before_accept", {req_ready, busy}, 2'b10);
      req_valid = 1'b1;
      req_zone  = z;
      req_hold  = hd;
      buzz_in   = 3'b000;
      exp_q.push_back({(code == 2'd0), code, 32'(ecyc + 1 + ex)});
      step();
      if (!keep_valid) req_valid = 1'b0;
      for (int i = 1; i < rdy; i++) begin
         if (keep_valid) begin
            req_zone = 2'($urandom_range(0, 3));
            req_hold = HOLD_W'($urandom);
         end
         buzz_in = sched[i];
         check("sensor_out", sensor_out, (i <= h) ? zoh : 3'b000);
         check("busy_not_ready", {req_ready, busy}, 2'b01);
         step();
      end
      buzz_in = 3'b000;
   endtask

   task automatic reset_mid_drive();
      check("ready_before_accept", {req_ready, busy}, 2'b10);
      req_valid = 1'b1;
      req_zone  = 2'd2;
      req_hold  = HOLD_W'(20);
      step();
      req_valid = 1'b0;
      for (int i = 1; i <= 3; i++) begin
         check("sensor_pre_reset", sensor_out, 3'b010);
         step();
      end
      rst_n = 1'b0;
      step();
      rst_n    = 1'b1;
      held_chk = 1'b0;
      check("sensor_after_reset", sensor_out, 3'b000);
      check("ready_after_reset", {req_ready, busy}, 2'b10);
      check("result_after_reset", {done, pass, fail_code}, 4'b0000);
      repeat (60) step();
      check("idle_after_reset", {req_ready, busy, sensor_out}, 5'b10000);
   endtask

   initial begin
      int         nz;
      int         hh;
      int         mode;
      logic [2:0] v;
      logic [1:0] z;
      logic [HOLD_W-1:0] hd;
      bit         kv;

      rst_n = 1'b0;
      repeat (3) step();
      rst_n = 1'b1;
      check("rst_sensor", sensor_out, 3'b000);
      check("rst_ready", req_ready, 1'b1);
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_pass", pass, 1'b0);
      check("rst_code", fail_code, 2'd0);

      // Directed test-plan cases.
      run_txn(2'd1, 5'd10, 5, 31, 3'b001, 1'b0);
      run_txn(2'd2, 5'd3, 0, 0, 3'b000, 1'b0);
      run_txn(2'd0, 5'd8, 0, 0, 3'b000, 1'b0);
      run_txn(2'd3, 5'd6, 4, 20, 3'b010, 1'b0);
      run_txn(2'd3, 5'd6, 4, 20, 3'b011, 1'b0);
      run_txn(2'd0, 5'd5, 3, 10, 3'b001, 1'b0);
      run_txn(2'd1, 5'd4, 4 + TIMEOUT - 1, 3, 3'b001, 1'b0);
      run_txn(2'd1, 5'd4, 4 + TIMEOUT, 3, 3'b001, 1'b0);
      run_txn(2'd2, 5'd31, 35, 2, 3'b010, 1'b0);
      reset_mid_drive();

      // Back-to-back single-cycle drives with valid held high and ena toggling.
      ena_rand = 1'b1;
      for (int n = 0; n < 6; n++) begin
         if (n % 2 == 0) run_txn(2'd1, 5'd0, $urandom_range(1, 10), $urandom_range(1, 31), 3'b001, 1'b1);
         else run_txn(2'd1, 5'd0, 0, 0, 3'b000, 1'b1);
      end

      // Randomized requests and buzzer behaviour.
      for (int n = 0; n < 25; n++) begin
         z    = 2'($urandom_range(0, 3));
         hd   = HOLD_W'($urandom_range(0, 31));
         hh   = (hd == '0) ? 1 : int'(hd);
         mode = $urandom_range(0, 2);
         nz   = $urandom_range(1, 7);
         if (mode == 1) v = (z == 2'd0) ? 3'(nz) : (3'b001 << (z - 2'd1));
         else if (mode == 2) v = 3'(nz);
         else v = 3'b000;
         kv = ($urandom_range(0, 1) == 1);
         run_txn(z, hd, $urandom_range(1, hh + TIMEOUT + 5), $urandom_range(1, 31), v, kv);
         if (!kv) repeat ($urandom_range(0, 3)) step();
      end

      req_valid = 1'b0;
      ena_rand  = 1'b0;
      repeat (5) step();
      check("pending_results", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/sensor_stim_tx.md
Name: sensor_stim_tx

Overview:
Transmit-side companion to the zone alarm detector. It accepts zone-test requests over a valid/ready handshake and drives the three sensor lines with a one-hot pattern for a programmed number of cycles. It then watches the detector's three buzzer lines and reports pass/fail for that zone. It is used for built-in self-test and as the bench driver for the alarm path.

Parameters:
HOLD_W, 5, width of req_hold (maximum hold is 2^HOLD_W-1 cycles)
TIMEOUT, 40, cycles after sensor release to wait for a buzzer response
GAP_CYCLES, 8, quiet cycles required after all buzzers are low, before the next request is accepted

Ports:
clk  in  1  clock
rst_n  in  1  reset, synchronous, active-low
ena  in  1  clock enable; when low, all state and outputs hold
req_valid  in  1  request present
req_ready  out  1  high only in IDLE
req_zone  in  2  0 = quiet test (expect no alarm); 1..3 = drive sensor[zone-1]
req_hold  in  HOLD_W  drive duration in cycles; 0 is treated as 1
sensor_out  out  3  one-hot sensor drive (bit0 = zone 1), registered
buzz_in  in  3  buzzer feedback from the detector
done  out  1  one-cycle pulse when a result is valid
pass  out  1  result, valid when done=1, held until the next done
fail_code  out  2  0 pass, 1 no response, 2 wrong zone, 3 spurious/multi-hot; held with pass
busy  out  1  high in any state other than IDLE

Behaviour:
- All sequential logic advances only when ena=1. rst_n is sampled only while ena=1.
- Reset values:
  - state=IDLE, sensor_out=0, done=0, pass=0, fail_code=0
  - req_ready=1, busy=0, all counters=0, obs register=0
- States: IDLE, DRIVE, WAIT_ACK, GAP.
- IDLE:
  - req_ready=1.
  - On req_valid&req_ready at edge T: latch zone and hold (0 becomes 1), clear obs, go to DRIVE.
  - sensor_out=onehot(zone) is visible from T+1; zone 0 gives 000.
- DRIVE:
  - sensor_out held for exactly hold cycles, then 000 on the next cycle.
  - Go to WAIT_ACK with the timeout counter cleared.
- Observation, active in both DRIVE and WAIT_ACK:
  - The first cycle with buzz_in!=0 latches buzz_in into obs. Later values are ignored.
  - buzz_in is treated as asynchronous to the stimulus and is sampled raw; no synchroniser.
- WAIT_ACK:
  - sensor_out=000.
  - Leave on the first cycle where obs!=0 (including obs latched during DRIVE; exit in the first WAIT_ACK cycle) or when the counter reaches TIMEOUT-1.
  - Assert done for one cycle with the result below, then go to GAP.
- Result, priority top-down:
  - obs not one-hot -> code 3.
  - zone=0 and obs!=0 -> code 3.
  - zone=0 and timeout -> pass.
  - zone!=0 and timeout -> code 1.
  - obs!=onehot(zone) -> code 2.
  - Otherwise pass (code 0).
- GAP:
  - sensor_out=000, req_ready=0.
  - The gap counter holds at 0 while buzz_in!=0.
  - Once buzz_in=0, count GAP_CYCLES consecutive cycles. Any nonzero buzz_in restarts the count.
  - After the count completes, go to IDLE.
- Request signals are ignored outside IDLE; no queueing.
- Counter widths:
  - Hold counter: HOLD_W bits.
  - Timeout and gap counters: clog2(max(TIMEOUT, GAP_CYCLES)+1) bits.
  - Counters saturate, never wrap.
- Reset mid-operation: the next enabled edge forces IDLE. sensor_out=0 and no done pulse are issued.
- ena low mid-DRIVE stretches the drive in wall-clock time, not in enabled cycles.

Decomposition:
- Shared package: state encoding (IDLE/DRIVE/WAIT_ACK/GAP), fail_code constants (FC_PASS=0, FC_NORESP=1, FC_WRONG=2, FC_SPUR=3), zone-to-one-hot function, one-hot check function.
- Optional sub-module sensor_stim_cnt: loadable saturating down/up counter, instantiated for hold, timeout and gap. Otherwise the block is a single module.

Test Plan:
- Zone 1, hold 10, into the real detector: buzz_in=001 appears during DRIVE. Required: done pulse with pass=1, fail_code=0. Then busy stays high until 31 buzzer cycles plus 8 quiet cycles have elapsed, then req_ready=1.
- Zone 2, hold 3, detector does not reach its threshold: required done after DRIVE (3) + TIMEOUT (40) cycles with pass=0, fail_code=1.
- Zone 0, hold 8, buzz_in tied 0: sensor_out stays 000. Required done after 8+40 cycles with pass=1.
- Zone 3, bench forces buzz_in=010: required fail_code=2. Repeat forcing buzz_in=011: required fail_code=3.
- Assert rst_n=0 during cycle 4 of a 20-cycle DRIVE: required sensor_out=000 and req_ready=1 on the next edge, with no done pulse.
- Hold req_valid high continuously with zone 1, hold 0: drive lasts exactly 1 cycle. Required: no second accept until GAP completes; accepts are exactly one IDLE cycle apart from the end of GAP. ena toggled 50% during the run: cycle counts scale with enabled edges only.
